// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S stereo transmitter with one-pair double buffer
// Optional saturating underrun counter enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_serializer #(
    parameter int SAMPLE_W = 24,
    parameter int BCK_HALF = 4
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                ena,
    input  logic [SAMPLE_W-1:0] sample_left,
    input  logic [SAMPLE_W-1:0] sample_right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                amp_i2s_bck,
    output logic                amp_i2s_ws,
    output logic                amp_i2s_d0,
    output logic                underrun,
    input  logic                underrun_clr,
    output logic [7:0]          underrun_cnt
);

    localparam int DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCK_HALF - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_nxt;
    logic                pend_full;
    logic [SAMPLE_W-1:0] pend_l;
    logic [SAMPLE_W-1:0] pend_r;
    logic [SAMPLE_W-1:0] frame_l;
    logic [SAMPLE_W-1:0] frame_r;
    logic [SAMPLE_W-1:0] word;
    logic                fall;
    logic                wrap;
    logic                capture;
    logic                ur_event;
    logic                slot_bit;

    assign fall         = ena && (div_cnt == DIV_MAX) && amp_i2s_bck;
    assign wrap         = fall && (bit_cnt == 6'd63);
    assign bit_nxt      = bit_cnt + 6'd1;
    assign capture      = sample_valid && !pend_full;
    assign ur_event     = wrap && !pend_full;
    assign sample_ready = !pend_full;

    // Data bit for the slot entered at this fall; slot 0 and slots past the word stay 0.
    always_comb begin
        word     = bit_nxt[5] ? frame_r : frame_l;
        slot_bit = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (bit_nxt[4:0] == 5'(SAMPLE_W - i)) begin
                slot_bit = word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pend_full <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
        end else if (capture) begin
            pend_full <= 1'b1;
            pend_l    <= sample_left;
            pend_r    <= sample_right;
        end else if (wrap) begin
            pend_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt     <= '0;
            amp_i2s_bck <= 1'b0;
            bit_cnt     <= 6'd0;
            amp_i2s_ws  <= 1'b0;
            amp_i2s_d0  <= 1'b0;
            frame_l     <= '0;
            frame_r     <= '0;
        end else if (!ena) begin
            div_cnt     <= '0;
            amp_i2s_bck <= 1'b0;
            bit_cnt     <= 6'd0;
            amp_i2s_ws  <= 1'b0;
            amp_i2s_d0  <= 1'b0;
            frame_l     <= '0;
            frame_r     <= '0;
        end else begin
            if (div_cnt == DIV_MAX) begin
                div_cnt     <= '0;
                amp_i2s_bck <= !amp_i2s_bck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt    <= bit_nxt;
                amp_i2s_ws <= bit_nxt[5];
                amp_i2s_d0 <= slot_bit;
            end
            // An empty buffer at the frame boundary plays silence.
            if (wrap) begin
                frame_l <= pend_full ? pend_l : '0;
                frame_r <= pend_full ? pend_r : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            underrun <= 1'b0;
        end else if (ur_event) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= 8'd0;
        end else if (ur_event) begin
            if (underrun_clr) begin
                cnt_q <= 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end else if (underrun_clr) begin
            cnt_q <= 8'd0;
        end
    end

    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - randomized bench for i2s_tx_serializer against a time-based frame model
module tb_i2s_tx_serializer;

    localparam int SW = 24;
    localparam int BH = 4;
    localparam int FR = 128 * BH;
    localparam int FR_S = 128;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          ena = 1'b0;
    logic [SW-1:0] sample_left = '0;
    logic [SW-1:0] sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          amp_i2s_bck;
    logic          amp_i2s_ws;
    logic          amp_i2s_d0;
    logic          underrun;
    logic          underrun_clr = 1'b0;
    logic [7:0]    underrun_cnt;

    logic          resetb_s = 1'b0;
    logic          ena_s = 1'b1;
    logic [SW-1:0] zero_s = '0;
    logic          valid_s = 1'b0;
    logic          clr_s = 1'b0;
    logic          ready_s;
    logic          bck_s;
    logic          ws_s;
    logic          d0_s;
    logic          ur_s;
    logic [7:0]    cnt_s;

    always #5 clk = !clk;

    i2s_tx_serializer #(.SAMPLE_W(SW), .BCK_HALF(BH)) dut (
        .clk(clk), .resetb(resetb), .ena(ena),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .amp_i2s_bck(amp_i2s_bck), .amp_i2s_ws(amp_i2s_ws), .amp_i2s_d0(amp_i2s_d0),
        .underrun(underrun), .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
    );

    i2s_tx_serializer #(.SAMPLE_W(SW), .BCK_HALF(1)) dut_sat (
        .clk(clk), .resetb(resetb_s), .ena(ena_s),
        .sample_left(zero_s), .sample_right(zero_s),
        .sample_valid(valid_s), .sample_ready(ready_s),
        .amp_i2s_bck(bck_s), .amp_i2s_ws(ws_s), .amp_i2s_d0(d0_s),
        .underrun(ur_s), .underrun_clr(clr_s), .underrun_cnt(cnt_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: n = clk edges since enable; frames and pending are the stereo pairs.
    int            n = 0;
    int            sat_n = 0;
    bit            m_full;
    logic [SW-1:0] m_pl, m_pr, m_fl, m_fr;
    bit            m_ur;
    int            m_cnt;
    int            rec_frame = -1;
    logic [SW-1:0] rec_l, rec_r;

    function automatic void model_reset();
        n = 0;
        m_full = 1'b0;
        m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
        m_ur = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_edge();
        bit wrap, cap, ev;
        if (!resetb) begin
            model_reset();
            return;
        end
        wrap = ena && ((n + 1) % FR == 0);
        cap  = sample_valid && !m_full;
        ev   = wrap && !m_full;
        if (wrap) begin
            m_fl = m_full ? m_pl : '0;
            m_fr = m_full ? m_pr : '0;
        end
        if (cap) begin
            m_pl = sample_left;
            m_pr = sample_right;
            m_full = 1'b1;
        end else if (wrap) begin
            m_full = 1'b0;
        end
        if (ev) m_ur = 1'b1;
        else if (underrun_clr) m_ur = 1'b0;
        if (CNT_EN) begin
            if (ev) m_cnt = underrun_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            else if (underrun_clr) m_cnt = 0;
        end
        if (ena) n++;
        else begin
            n = 0;
            m_fl = '0;
            m_fr = '0;
        end
    endfunction

    task automatic step();
        int b, k;
        logic [SW-1:0] w;
        bit e_bck, e_ws, e_d0;
        @(posedge clk);
        model_edge();
        if (resetb_s) sat_n++;
        #1;
        e_bck = ((n / BH) % 2) == 1;
        b = (n / (2 * BH)) % 64;
        e_ws = b >= 32;
        k = b % 32;
        w = e_ws ? m_fr : m_fl;
        e_d0 = (k >= 1 && k <= SW) ? w[SW - k] : 1'b0;
        check("bck", amp_i2s_bck, e_bck);
        check("ws", amp_i2s_ws, e_ws);
        check("d0", amp_i2s_d0, e_d0);
        check("ready", sample_ready, !m_full);
        check("underrun", underrun, m_ur);
        check("underrun_cnt", underrun_cnt, m_cnt);
        if (rec_frame >= 0 && n / FR == rec_frame && n % (2 * BH) == BH && k >= 1 && k <= SW) begin
            if (b < 32) rec_l[SW - k] = amp_i2s_d0;
            else        rec_r[SW - k] = amp_i2s_d0;
        end
        if (sat_n == 200 * FR_S + 2) check("sat_cnt_200", cnt_s, CNT_EN ? 200 : 0);
        if (sat_n == 300 * FR_S + 2) begin
            check("sat_cnt_300", cnt_s, CNT_EN ? 255 : 0);
            check("sat_flag", ur_s, 1);
        end
    endtask

    int acc;
    int guard;
    int saved_cnt;
    logic [SW-1:0] saved_l, saved_r;

    initial begin
        model_reset();
        repeat (3) step();
        resetb = 1'b1;
        resetb_s = 1'b1;
        ena = 1'b1;
        repeat (300) step();
        // Asynchronous reset mid-frame
        #2 resetb = 1'b0;
        #1;
        check("async_bck", amp_i2s_bck, 0);
        check("async_ws", amp_i2s_ws, 0);
        check("async_d0", amp_i2s_d0, 0);
        check("async_ready", sample_ready, 1);
        model_reset();
        repeat (3) step();
        resetb = 1'b1;

        // Single directed pair, then underrun and coincident clear
        sample_left = 24'h800001;
        sample_right = 24'h7FFFFF;
        sample_valid = 1'b1;
        rec_l = 24'h555555; rec_r = 24'h555555; rec_frame = 1;
        step();
        sample_valid = 1'b0;
        while (n < 2 * FR + 1) step();
        check("pair_left", rec_l, 24'h800001);
        check("pair_right", rec_r, 24'h7FFFFF);
        check("ur_after_idle", underrun, 1);
        check("cnt_after_idle", underrun_cnt, CNT_EN ? 1 : 0);
        rec_frame = -1;
        while (n < 3 * FR - 1) step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("clr_vs_event_flag", underrun, 1);
        check("clr_vs_event_cnt", underrun_cnt, CNT_EN ? 1 : 0);

        // Backpressure: valid held high for four frames
        acc = 0;
        underrun_clr = 1'b1;
        for (int i = 0; i < 4 * FR; i++) begin
            sample_valid = 1'b1;
            sample_left = SW'($urandom);
            sample_right = SW'($urandom);
            if (sample_ready) acc++;
            step();
            underrun_clr = 1'b0;
        end
        check("bp_accepts", acc, 4);
        check("bp_no_underrun", underrun, 0);

        // Random valid and occasional clears
        for (int i = 0; i < 4 * FR; i++) begin
            sample_valid = ($urandom % 8) == 0;
            sample_left = SW'($urandom);
            sample_right = SW'($urandom);
            underrun_clr = ($urandom % 256) == 0;
            step();
        end
        underrun_clr = 1'b0;

        // Drop ena at bit_cnt 40 with the pending buffer full
        guard = 0;
        sample_valid = 1'b1;
        while (!(m_full && (n / (2 * BH)) % 64 == 40) && guard < 3 * FR) begin
            sample_left = SW'($urandom);
            sample_right = SW'($urandom);
            step();
            guard++;
        end
        check("ena_drop_setup", guard < 3 * FR, 1);
        sample_valid = 1'b0;
        ena = 1'b0;
        saved_l = m_pl;
        saved_r = m_pr;
        saved_cnt = m_cnt;
        repeat (20) step();
        check("ena_off_bck", amp_i2s_bck, 0);
        check("ena_off_ws", amp_i2s_ws, 0);
        check("ena_off_d0", amp_i2s_d0, 0);
        ena = 1'b1;
        rec_l = 24'h555555; rec_r = 24'h555555; rec_frame = 1;
        while (n < FR + 10) step();
        check("ena_cnt_kept", underrun_cnt, saved_cnt);
        while (n < 2 * FR - 1) step();
        check("ena_pair_left", rec_l, saved_l);
        check("ena_pair_right", rec_r, saved_r);
        rec_frame = -1;

        while (sat_n < 300 * FR_S + 5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
